// File: rtl/stream_seg_accumulator.sv
// Streaming word accumulator built from SEG_W-wide segments whose carries ripple
// one segment per cycle, so no adder chain ever spans more than one segment.
module stream_seg_accumulator #(
    parameter int DATA_W = 32,
    parameter int SEG_W  = 16,
    parameter int NSEG   = 3,
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W:0]        len,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   busy,
    output logic                   done,
    output logic [SEG_W*NSEG-1:0]  result,
    output logic                   overflow
);
    localparam int ACC_W = SEG_W * NSEG;
    localparam int CNT_W = $clog2(NSEG + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    if (DATA_W > ACC_W) begin : g_width_check
        $error("stream_seg_accumulator: DATA_W must not exceed SEG_W*NSEG");
    end

    logic [1:0]        state_r;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [CNT_W-1:0]  drain_cnt_r;
    logic [ACC_W-1:0]  data_q_r;
    logic              data_v_r;
    logic              busy_r;
    logic              done_r;
    logic [ACC_W-1:0]  result_r;
    logic              overflow_r;
    logic              ovf_acc_r;

    logic [SEG_W-1:0]  seg_r   [NSEG];
    logic              carry_r [NSEG];
    logic              cin_s   [NSEG];
    logic [SEG_W:0]    sum_s   [NSEG];
    logic [ACC_W-1:0]  acc_s;
    logic              accept_s;
    logic              last_s;

    assign accept_s = (state_r == S_IDLE) && start;
    assign last_s   = ({1'b0, mem_addr_r} == (len_r - (ADDR_W+1)'(1)));

    // Carry into each segment comes only from the registered carry of the one below.
    always_comb begin
        cin_s[0] = 1'b0;
        for (int k = 1; k < NSEG; k++) begin
            cin_s[k] = carry_r[k-1];
        end
    end

    // Per-segment adders and the concatenated accumulator view.
    always_comb begin
        acc_s = {ACC_W{1'b0}};
        for (int k = 0; k < NSEG; k++) begin
            sum_s[k] = {1'b0, seg_r[k]}
                     + {1'b0, (data_v_r ? data_q_r[k*SEG_W +: SEG_W] : {SEG_W{1'b0}})}
                     + {{SEG_W{1'b0}}, cin_s[k]};
            acc_s[k*SEG_W +: SEG_W] = seg_r[k];
        end
    end

    // Segment and carry registers; the top carry is not kept here but folded into overflow.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NSEG; k++) begin
            if (rst || accept_s) begin
                seg_r[k]   <= {SEG_W{1'b0}};
                carry_r[k] <= 1'b0;
            end else begin
                seg_r[k]   <= sum_s[k][SEG_W-1:0];
                carry_r[k] <= (k == NSEG - 1) ? 1'b0 : sum_s[k][SEG_W];
            end
        end
    end

    // Run control, fetch addressing, data register and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            len_r       <= {(ADDR_W+1){1'b0}};
            mem_addr_r  <= {ADDR_W{1'b0}};
            drain_cnt_r <= {CNT_W{1'b0}};
            data_q_r    <= {ACC_W{1'b0}};
            data_v_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            result_r    <= {ACC_W{1'b0}};
            overflow_r  <= 1'b0;
            ovf_acc_r   <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            data_v_r  <= (state_r == S_FETCH);
            data_q_r  <= (state_r == S_FETCH) ? ACC_W'(mem_data) : {ACC_W{1'b0}};
            ovf_acc_r <= ovf_acc_r | sum_s[NSEG-1][SEG_W];
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        len_r      <= len;
                        mem_addr_r <= {ADDR_W{1'b0}};
                        ovf_acc_r  <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= (len == {(ADDR_W+1){1'b0}}) ? S_DONE : S_FETCH;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    if (last_s) begin
                        state_r     <= S_DRAIN;
                        drain_cnt_r <= CNT_W'(NSEG - 1);
                    end else begin
                        mem_addr_r <= mem_addr_r + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    // One cycle for the last word's add plus NSEG-1 carry flush steps.
                    if (drain_cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= S_DONE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_r    <= S_IDLE;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b1;
                    result_r   <= acc_s;
                    overflow_r <= ovf_acc_r;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr = mem_addr_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_stream_seg_accumulator.sv
// Directed bench: a default-parameter instance and an NSEG=2 instance, each fed
// from a bench-side combinational memory.
module tb_stream_seg_accumulator;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic [8:0]  len, len2;
    logic [7:0]  mem_addr, mem_addr2;
    logic [31:0] mem_data, mem_data2;
    logic        busy, busy2, done, done2, overflow, overflow2;
    logic [47:0] result;
    logic [31:0] result2;
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];

    int checks = 0;
    int errors = 0;
    int done_edge, addr_bad, busy0, dcount;

    always #5 clk = ~clk;

    assign mem_data  = mem0[mem_addr];
    assign mem_data2 = mem1[mem_addr2];

    stream_seg_accumulator u_dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .mem_addr(mem_addr),
        .mem_data(mem_data), .busy(busy), .done(done), .result(result), .overflow(overflow)
    );

    stream_seg_accumulator #(.NSEG(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .len(len2), .mem_addr(mem_addr2),
        .mem_data(mem_data2), .busy(busy2), .done(done2), .result(result2), .overflow(overflow2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run on instance sel, return the edge (start accept = 0) at which done was seen.
    task automatic run(input int sel, input logic [8:0] l, input int glitch,
                       output int d_edge, output int a_bad, output int b0);
        if (sel == 0) begin start = 1'b1; len = l; end
        else          begin start2 = 1'b1; len2 = l; end
        tick();
        start = 1'b0; start2 = 1'b0;
        a_bad = 0; d_edge = -1; b0 = (sel == 0) ? int'(busy) : int'(busy2);
        for (int k = 0; k < 400; k++) begin
            if (k > 0) tick();
            if (k == glitch) begin
                start = 1'b1; len = 9'd0;
            end else if (k == glitch + 1) begin
                start = 1'b0;
            end
            if (k < int'(l)) begin
                if (((sel == 0) ? mem_addr : mem_addr2) !== k[7:0]) a_bad++;
            end
            if (((sel == 0) ? done : done2) === 1'b1) begin
                d_edge = k;
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 32'h0;
            mem1[i] = 32'h0;
        end
        rst = 1'b1; start = 1'b0; start2 = 1'b0; len = 9'd0; len2 = 9'd0;
        tick(); tick();
        rst = 1'b0;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_result", {16'd0, result}, 64'd0);
        check("reset_overflow", {63'd0, overflow}, 64'd0);
        check("reset_addr", {56'd0, mem_addr}, 64'd0);

        // Four words of 0xFFFF.
        for (int i = 0; i < 4; i++) mem0[i] = 32'h0000FFFF;
        run(0, 9'd4, -1, done_edge, addr_bad, busy0);
        check("len4_done_edge", 64'(done_edge), 64'd8);
        check("len4_addr_seq", 64'(addr_bad), 64'd0);
        check("len4_result", {16'd0, result}, 64'h00000003FFFC);
        check("len4_overflow", {63'd0, overflow}, 64'd0);
        check("len4_busy_in_done", {63'd0, busy}, 64'd0);
        check("len4_busy_after_accept", 64'(busy0), 64'd1);
        tick();
        check("len4_done_pulse", {63'd0, done}, 64'd0);

        // Carry ripple through all segments.
        mem0[0] = 32'hFFFFFFFF; mem0[1] = 32'hFFFFFFFF;
        run(0, 9'd2, -1, done_edge, addr_bad, busy0);
        check("ripple_done_edge", 64'(done_edge), 64'd6);
        check("ripple_result", {16'd0, result}, 64'h0001FFFFFFFE);
        check("ripple_overflow", {63'd0, overflow}, 64'd0);

        // NSEG=2 wrap with overflow.
        mem1[0] = 32'hFFFFFFFF; mem1[1] = 32'h00000002;
        run(1, 9'd2, -1, done_edge, addr_bad, busy0);
        check("nseg2_done_edge", 64'(done_edge), 64'd5);
        check("nseg2_result", {32'd0, result2}, 64'h1);
        check("nseg2_overflow", {63'd0, overflow2}, 64'd1);

        // Zero-length run.
        tick();
        run(0, 9'd0, -1, done_edge, addr_bad, busy0);
        check("len0_done_edge", 64'(done_edge), 64'd1);
        check("len0_result", {16'd0, result}, 64'd0);
        check("len0_overflow", {63'd0, overflow}, 64'd0);
        check("len0_addr", {56'd0, mem_addr}, 64'd0);

        // Reset at edge 3 of a len=10 run, then a fresh len=1 run.
        tick();
        for (int i = 0; i < 10; i++) mem0[i] = 32'h11;
        start = 1'b1; len = 9'd10;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_addr", {56'd0, mem_addr}, 64'd0);
        dcount = 0;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) dcount++;
            tick();
        end
        check("abort_no_done", 64'(dcount), 64'd0);
        mem0[0] = 32'h5;
        run(0, 9'd1, -1, done_edge, addr_bad, busy0);
        check("after_abort_done_edge", 64'(done_edge), 64'd5);
        check("after_abort_result", {16'd0, result}, 64'h5);

        // Start pulsed mid-run is ignored; start in the done cycle launches a new run.
        tick();
        mem0[0] = 32'h1; mem0[1] = 32'h2; mem0[2] = 32'h3;
        run(0, 9'd3, 2, done_edge, addr_bad, busy0);
        check("midrun_done_edge", 64'(done_edge), 64'd7);
        check("midrun_result", {16'd0, result}, 64'h6);
        run(0, 9'd1, -1, done_edge, addr_bad, busy0);
        check("donecycle_busy_next", 64'(busy0), 64'd1);
        check("donecycle_done_edge", 64'(done_edge), 64'd5);
        check("donecycle_result", {16'd0, result}, 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
